// File: rtl/puf_resp_ctrl.sv
// Challenge sequencer and response generator for the RO PUF: runs the counter
// pair once per challenge, compares the synchronised counts, builds the response.
module puf_resp_ctrl #(
    parameter int N_CHAL  = 8,
    parameter int CW      = 4,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [CW-1:0]             i_count1,
    input  logic [CW-1:0]             i_count2,
    output logic                      o_ctr_reset,
    output logic                      o_ctr_en,
    output logic [$clog2(N_CHAL)-1:0] o_chal_idx,
    output logic                      o_busy,
    output logic [N_CHAL-1:0]         o_response,
    output logic                      o_resp_valid,
    output logic                      o_timeout_err,
    output logic                      o_tie_flag
);

    localparam int IW = $clog2(N_CHAL);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_SETTLE,
        S_CMP,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_ph;
    logic [TW-1:0]   r_tmo;
    logic [IW-1:0]   r_chal_idx;
    logic            r_chal_tmo;
    logic [CW-1:0]   r_s1_cnt [2];
    logic [CW-1:0]   r_s2_cnt [2];
    logic [N_CHAL-1:0] r_response;
    logic            r_ctr_reset;
    logic            r_ctr_en;
    logic            r_busy;
    logic            r_resp_valid;
    logic            r_timeout_err;
    logic            r_tie_flag;

    logic [CW-1:0]   w_cnt_in [2];
    logic            w_sat;
    logic [TW-1:0]   w_tmo_inc;
    logic            w_tmo_hit;
    logic            w_tmo_set;
    logic            w_accept;
    logic            w_cmp;
    logic            w_last;
    logic            w_cmp_bit;
    logic            w_tie;
    logic [N_CHAL-1:0] w_resp_next;

    assign w_cnt_in[0] = i_count1;
    assign w_cnt_in[1] = i_count2;

    // Two-flop synchronisers for the counts arriving from the oscillator domain
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_s1_cnt[gi] <= '0;
                    r_s2_cnt[gi] <= '0;
                end else begin
                    r_s1_cnt[gi] <= w_cnt_in[gi];
                    r_s2_cnt[gi] <= r_s1_cnt[gi];
                end
            end
        end
    endgenerate

    assign w_sat     = (&r_s2_cnt[0]) | (&r_s2_cnt[1]);
    assign w_tmo_inc = r_tmo + TW'(1);
    assign w_tmo_hit = (w_tmo_inc == TW'(TIMEOUT));
    assign w_accept  = (r_state == S_IDLE) && i_start;
    assign w_cmp     = (r_state == S_CMP);
    assign w_last    = (r_chal_idx == IW'(N_CHAL - 1));
    assign w_tie     = (r_s2_cnt[0] == r_s2_cnt[1]);
    // A timed-out challenge always yields 0, whatever the counts say
    assign w_cmp_bit = !r_chal_tmo && (r_s2_cnt[0] > r_s2_cnt[1]);

    generate
        for (gi = 0; gi < N_CHAL; gi++) begin : g_resp
            assign w_resp_next[gi] = w_accept ? 1'b0 :
                                     (w_cmp && (r_chal_idx == IW'(gi))) ? w_cmp_bit :
                                     r_response[gi];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_tmo_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_CLR;
                end
            end
            S_CLR: begin
                if (r_ph == PW'(1)) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_sat) begin
                    w_state_next = S_SETTLE;
                end else if (w_tmo_hit) begin
                    w_state_next = S_SETTLE;
                    w_tmo_set    = 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_ph == PW'(SETTLE - 1)) begin
                    w_state_next = S_CMP;
                end
            end
            S_CMP: begin
                w_state_next = w_last ? S_DONE : S_CLR;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Counter-pair controls are registered from the next state so they reach
    // the oscillator domain glitch-free while still tracking the state exactly.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_ph          <= '0;
            r_tmo         <= '0;
            r_chal_idx    <= '0;
            r_chal_tmo    <= 1'b0;
            r_response    <= '0;
            r_ctr_reset   <= 1'b1;
            r_ctr_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_tie_flag    <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_state_next != r_state) begin
                r_ph <= '0;
            end else if ((r_state == S_CLR) || (r_state == S_SETTLE)) begin
                r_ph <= r_ph + PW'(1);
            end

            if ((w_state_next == S_RUN) && (r_state != S_RUN)) begin
                r_tmo <= '0;
            end else if (r_state == S_RUN) begin
                r_tmo <= w_tmo_inc;
            end

            if (w_accept) begin
                r_chal_idx <= '0;
            end else if (w_cmp && !w_last) begin
                r_chal_idx <= r_chal_idx + IW'(1);
            end

            if (r_state == S_CLR) begin
                r_chal_tmo <= 1'b0;
            end else if (w_tmo_set) begin
                r_chal_tmo <= 1'b1;
            end

            if (w_accept) begin
                r_timeout_err <= 1'b0;
            end else if (w_tmo_set) begin
                r_timeout_err <= 1'b1;
            end

            if (w_accept) begin
                r_tie_flag <= 1'b0;
            end else if (w_cmp && w_tie) begin
                r_tie_flag <= 1'b1;
            end

            r_response   <= w_resp_next;
            r_ctr_reset  <= (w_state_next == S_IDLE) || (w_state_next == S_CLR) ||
                            (w_state_next == S_DONE);
            r_ctr_en     <= (w_state_next == S_RUN);
            r_busy       <= (w_state_next != S_IDLE);
            r_resp_valid <= (w_state_next == S_DONE);
        end
    end

    assign o_ctr_reset   = r_ctr_reset;
    assign o_ctr_en      = r_ctr_en;
    assign o_chal_idx    = r_chal_idx;
    assign o_busy        = r_busy;
    assign o_response    = r_response;
    assign o_resp_valid  = r_resp_valid;
    assign o_timeout_err = r_timeout_err;
    assign o_tie_flag    = r_tie_flag;

endmodule

// File: doc/puf_resp_ctrl.md
Name: puf_resp_ctrl

Overview:
Challenge sequencer and response generator for the RO PUF, sitting directly downstream of the dual ring-oscillator counter pair. For each challenge index it clears and enables the counter pair and waits for either counter to saturate. It then synchronises and compares the two counts and shifts one response bit into an N_CHAL-bit response word. It also drives the RO-pair select index to the oscillator mux upstream.

Parameters:
N_CHAL, 8, number of challenges per run = response width (≥2)
CW, 4, width of each oscillator count input
SETTLE, 3, system-clock cycles to wait after en drops before sampling counts (≥2)
TIMEOUT, 1023, max RUN-state cycles per challenge before forced abort

Ports:
clk  input  1  system clock; every flop in this block is on this clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a run; ignored while busy=1
count1  input  CW  count from oscillator c1 counter (asynchronous domain)
count2  input  CW  count from oscillator c2 counter (asynchronous domain)
ctr_reset  output  1  reset to counter pair
ctr_en  output  1  enable to counter pair
chal_idx  output  $clog2(N_CHAL)  RO-pair select for the current challenge
busy  output  1  high from the cycle after start is accepted until resp_valid
response  output  N_CHAL  response word; bit i is the result of challenge i
resp_valid  output  1  one-cycle pulse when response is complete
timeout_err  output  1  sticky per run: some challenge hit TIMEOUT
tie_flag  output  1  sticky per run: some challenge compared equal

Behaviour:
- Reset (synchronous): state=IDLE. ctr_reset=1, ctr_en=0, chal_idx=0, busy=0, response=0, resp_valid=0, timeout_err=0, tie_flag=0, all internal counters=0. Reset mid-run aborts the run immediately; no resp_valid is produced.
- Synchroniser: count1 and count2 each pass through a 2-flop synchroniser (s1, s2). Only the s2 values are used for decisions.
- Saturation detect: sat = (&s2_count1) | (&s2_count2).
- IDLE: ctr_reset=1, ctr_en=0. If start=1, go to CLR: chal_idx←0, response←0, timeout_err←0, tie_flag←0, busy←1.
- CLR: ctr_reset=1, ctr_en=0 for exactly 2 cycles, then RUN. The timeout counter is cleared on entry to RUN.
- RUN: ctr_reset=0, ctr_en=1. The timeout counter increments each cycle.
  - If sat=1, go to SETTLE.
  - Else if the timeout counter reaches TIMEOUT, set timeout_err=1 and go to SETTLE.
  - Saturation takes priority if both conditions are true in the same cycle.
- SETTLE: ctr_en=0, ctr_reset=0. Stay SETTLE cycles, then CMP. This guarantees synchroniser outputs are stable because saturated or disabled counters do not move.
- CMP (1 cycle): response[chal_idx] ← (s2_count1 > s2_count2), unsigned compare.
  - If the counts are equal, the bit is 0 and tie_flag←1.
  - If a timeout occurred on this challenge, the bit is 0 regardless of counts.
  - If chal_idx == N_CHAL-1, go to DONE. Otherwise chal_idx←chal_idx+1 and go to CLR.
- DONE (1 cycle): resp_valid=1, busy←0, then IDLE.
  - response, timeout_err and tie_flag hold their values until the next accepted start or reset.
  - chal_idx holds N_CHAL-1 until the next accepted start.
- Latency per challenge without timeout: 2 (CLR) + RUN cycles until sat is seen (≥1) + SETTLE + 1 (CMP). DONE adds 1 cycle per run.
- start asserted while busy=1, or in the DONE cycle, is ignored. It is not queued.
- chal_idx changes only on the CMP→CLR transition, so the RO mux switches while the counters are held in reset.

Test Plan:
- Reset, then start. Per challenge, model counters with count1 reaching 4'hF while count2=4'h9 for even idx; count2 reaching 4'hF while count1=4'h3 for odd idx → response=8'h55, resp_valid 1-cycle pulse, timeout_err=0, tie_flag=0, busy low after DONE.
- Challenge 3: both counts reach 4'hF in the same cycle; others count1 wins → response=8'hF7, tie_flag=1.
- Challenge 5: counts never saturate (held at 4'h2/4'h1) → RUN exits after 1023 cycles, response[5]=0, timeout_err=1, remaining challenges complete normally.
- Pulse start every cycle during a run → only the first is accepted, exactly one resp_valid, chal_idx sequence 0..7 with no restart.
- Assert reset during RUN of challenge 4 → next cycle state=IDLE, ctr_reset=1, ctr_en=0, response=0, busy=0, no resp_valid; a new start completes a full 8-challenge run.
- Check ctr_en low and chal_idx stable throughout every CLR and SETTLE window; CLR is exactly 2 cycles and SETTLE is exactly 3 cycles.
